// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB slave port.
// Latency: request seen in IDLE -> SETUP +1, ACCESS +2, done pulse +3 (+1 per slave wait cycle).
// Backpressure: slave wait states stretch ACCESS; other requests stay pending until the next IDLE.
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES wait cycles).
module apb_rr_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_done,
  output logic [DATA_WIDTH-1:0]         o_req_rdata,
  output logic                          o_req_err,
  output logic                          o_busy,
  output logic                          o_psel,
  output logic                          o_penable,
  output logic                          o_pwrite,
  output logic [ADDR_WIDTH-1:0]         o_paddr,
  output logic [DATA_WIDTH-1:0]         o_pwdata,
  input  logic                          i_pready,
  input  logic                          i_pslverr,
  input  logic [DATA_WIDTH-1:0]         i_prdata
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [GW-1:0]           r_last_grant, w_last_grant_nxt;
  logic [GW-1:0]           r_grant, w_grant_nxt;
  logic                    r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
  logic [NUM_REQ-1:0]      r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_busy, w_busy_nxt;

  logic                    w_found_lo, w_found_hi;
  logic [GW-1:0]           w_win_lo, w_win_hi, w_winner;
  logic                    w_sel_write;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
`endif

  // Round-robin pick: first set request above last_grant, otherwise first set request from 0.
  always_comb begin
    w_found_lo  = 1'b0;
    w_found_hi  = 1'b0;
    w_win_lo    = '0;
    w_win_hi    = '0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_win_lo   = GW'(i);
      end
      if (i_req[i] && !w_found_hi && (GW'(i) > r_last_grant)) begin
        w_found_hi = 1'b1;
        w_win_hi   = GW'(i);
      end
    end
    w_winner = w_found_hi ? w_win_hi : w_win_lo;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == w_winner) begin
        w_sel_write = i_req_write[i];
        w_sel_addr  = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output decode; done/err/rdata default to 0 so they only pulse in DONE.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_psel_nxt       = r_psel;
    w_penable_nxt    = r_penable;
    w_pwrite_nxt     = r_pwrite;
    w_paddr_nxt      = r_paddr;
    w_pwdata_nxt     = r_pwdata;
    w_done_nxt       = '0;
    w_rdata_nxt      = '0;
    w_err_nxt        = 1'b0;
`ifdef APB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        if (w_found_lo) begin
          w_psel_nxt       = 1'b1;
          w_pwrite_nxt     = w_sel_write;
          w_paddr_nxt      = w_sel_addr;
          w_pwdata_nxt     = w_sel_wdata;
          w_grant_nxt      = w_winner;
          w_last_grant_nxt = w_winner;
          w_state_nxt      = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        w_cnt_nxt     = '0;
`endif
      end
      S_ACCESS: begin
        if (i_pready) begin
          w_rdata_nxt          = r_pwrite ? '0 : i_prdata;
          w_err_nxt            = i_pslverr;
          w_psel_nxt           = 1'b0;
          w_penable_nxt        = 1'b0;
          w_done_nxt[r_grant]  = 1'b1;
          w_state_nxt          = S_DONE;
        end
`ifdef APB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          // Slave never answered: abort with an error and no data.
          w_err_nxt            = 1'b1;
          w_psel_nxt           = 1'b0;
          w_penable_nxt        = 1'b0;
          w_done_nxt[r_grant]  = 1'b1;
          w_cnt_nxt            = CW'(TIMEOUT_CYCLES);
          w_state_nxt          = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs; async reset clears everything and rearms requester 0 as first.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_done       <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_psel       <= w_psel_nxt;
      r_penable    <= w_penable_nxt;
      r_pwrite     <= w_pwrite_nxt;
      r_paddr      <= w_paddr_nxt;
      r_pwdata     <= w_pwdata_nxt;
      r_done       <= w_done_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
`ifdef APB_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
`endif
    end
  end

  assign o_req_done  = r_done;
  assign o_req_rdata = r_rdata;
  assign o_req_err   = r_err;
  assign o_busy      = r_busy;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master (NUM_REQ=2): per-cycle vector table plus
// hand-written sequences for reset mid-transfer, fairness and long waits / timeout.
module tb_apb_rr_master;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req;
  logic [1:0]  i_req_write;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic [1:0]  o_req_done;
  logic [31:0] o_req_rdata;
  logic        o_req_err, o_busy, o_psel, o_penable, o_pwrite;
  logic [31:0] o_paddr, o_pwdata;
  logic        i_pready, i_pslverr;
  logic [31:0] i_prdata;

  int checks = 0;
  int errors = 0;

  assign i_req_addr  = {addr1, addr0};
  assign i_req_wdata = {wd1, wd0};

  always #5 i_clk = ~i_clk;

  apb_rr_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req(i_req), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_done(o_req_done), .o_req_rdata(o_req_rdata), .o_req_err(o_req_err),
    .o_busy(o_busy), .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_paddr(o_paddr), .o_pwdata(o_pwdata),
    .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0, a1, w0, w1;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        e_psel, e_pen, e_pwrite;
    logic [31:0] e_paddr, e_pwdata;
    logic [1:0]  e_done;
    logic [31:0] e_rdata;
    logic        e_err, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic [1:0] req, input logic [1:0] wr,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] w0, input logic [31:0] w1,
                     input logic pready, input logic pslverr, input logic [31:0] prdata,
                     input logic e_psel, input logic e_pen, input logic e_pwrite,
                     input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                     input logic [1:0] e_done, input logic [31:0] e_rdata,
                     input logic e_err, input logic e_busy);
    vec_t v;
    v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.pready = pready; v.pslverr = pslverr; v.prdata = prdata;
    v.e_psel = e_psel; v.e_pen = e_pen; v.e_pwrite = e_pwrite;
    v.e_paddr = e_paddr; v.e_pwdata = e_pwdata; v.e_done = e_done;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  logic [1:0] exp_g[4];
  int         n;

  initial begin
    i_reset = 1'b1; i_req = '0; i_req_write = '0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    i_pready = 1'b0; i_pslverr = 1'b0; i_prdata = '0;

    // Single write from requester 0, slave ready immediately; rdata must read 0 for writes.
    add(2'b01, 2'b01, 32'h4, 0, 32'hA5A5_0001, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 32'h4, 32'hA5A5_0001, 2'b00, 0, 0, 1);
    add(2'b01, 2'b01, 32'h4, 0, 32'hA5A5_0001, 0, 1, 0, 32'hFFFF_FFFF, 1, 1, 1, 32'h4, 32'hA5A5_0001, 2'b00, 0, 0, 1);
    add(2'b01, 2'b01, 32'h4, 0, 32'hA5A5_0001, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 32'h4, 32'hA5A5_0001, 2'b01, 0, 0, 1);
    add(2'b00, 2'b01, 32'h4, 0, 32'hA5A5_0001, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 32'h4, 32'hA5A5_0001, 2'b00, 0, 0, 0);
    // Read from requester 1 with 3 wait cycles; pslverr while not ready must be ignored.
    add(2'b10, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 0, 0, 0, 1, 0, 0, 32'h8, 32'hDEAD_0002, 2'b00, 0, 0, 1);
    add(2'b10, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 0, 0, 0, 1, 1, 0, 32'h8, 32'hDEAD_0002, 2'b00, 0, 0, 1);
    add(2'b10, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 0, 1, 0, 1, 1, 0, 32'h8, 32'hDEAD_0002, 2'b00, 0, 0, 1);
    add(2'b10, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 0, 1, 0, 1, 1, 0, 32'h8, 32'hDEAD_0002, 2'b00, 0, 0, 1);
    add(2'b10, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 0, 1, 0, 1, 1, 0, 32'h8, 32'hDEAD_0002, 2'b00, 0, 0, 1);
    add(2'b10, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 1, 0, 32'h1234_5678, 0, 0, 0, 32'h8, 32'hDEAD_0002, 2'b10, 32'h1234_5678, 0, 1);
    add(2'b00, 2'b00, 0, 32'h8, 0, 32'hDEAD_0002, 0, 0, 0, 0, 0, 0, 32'h8, 32'hDEAD_0002, 2'b00, 0, 0, 0);
    // Slave error on a read from requester 0: err only during the done pulse.
    add(2'b01, 2'b00, 32'hC, 0, 0, 0, 1, 1, 32'h55AA_55AA, 1, 0, 0, 32'hC, 0, 2'b00, 0, 0, 1);
    add(2'b01, 2'b00, 32'hC, 0, 0, 0, 1, 1, 32'h55AA_55AA, 1, 1, 0, 32'hC, 0, 2'b00, 0, 0, 1);
    add(2'b01, 2'b00, 32'hC, 0, 0, 0, 1, 1, 32'h55AA_55AA, 0, 0, 0, 32'hC, 0, 2'b01, 32'h55AA_55AA, 1, 1);
    add(2'b00, 2'b00, 32'hC, 0, 0, 0, 1, 1, 32'h55AA_55AA, 0, 0, 0, 32'hC, 0, 2'b00, 0, 0, 0);

    // Reset state
    #3;
    chk("rst_psel", o_psel, 0);
    chk("rst_penable", o_penable, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_req_done, 0);
    chk("rst_paddr", o_paddr, 0);
    chk("rst_err", o_req_err, 0);
    step(); step();
    i_reset = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < vecs.size(); i++) begin
      i_req = vecs[i].req; i_req_write = vecs[i].wr;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1; wd0 = vecs[i].w0; wd1 = vecs[i].w1;
      i_pready = vecs[i].pready; i_pslverr = vecs[i].pslverr; i_prdata = vecs[i].prdata;
      step();
      chk($sformatf("v%0d_psel", i), o_psel, vecs[i].e_psel);
      chk($sformatf("v%0d_penable", i), o_penable, vecs[i].e_pen);
      chk($sformatf("v%0d_pwrite", i), o_pwrite, vecs[i].e_pwrite);
      chk($sformatf("v%0d_paddr", i), o_paddr, vecs[i].e_paddr);
      chk($sformatf("v%0d_pwdata", i), o_pwdata, vecs[i].e_pwdata);
      chk($sformatf("v%0d_done", i), o_req_done, vecs[i].e_done);
      chk($sformatf("v%0d_rdata", i), o_req_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_err", i), o_req_err, vecs[i].e_err);
      chk($sformatf("v%0d_busy", i), o_busy, vecs[i].e_busy);
    end

    // Reset during ACCESS: outputs drop without a clock edge, no done pulse follows.
    i_req = 2'b10; i_req_write = 2'b00; addr1 = 32'h20; i_pready = 1'b0; i_pslverr = 1'b0;
    step(); step();
    chk("rmid_in_access", o_penable, 1);
    i_reset = 1'b1;
    #1;
    chk("rmid_psel", o_psel, 0);
    chk("rmid_penable", o_penable, 0);
    chk("rmid_busy", o_busy, 0);
    i_pready = 1'b1;
    step();
    chk("rmid_done0", o_req_done, 0);
    step();
    chk("rmid_done1", o_req_done, 0);

    // Fairness: both requesters held high for 4 transfers -> 0,1,0,1, four cycles apart.
    i_reset = 1'b0;
    i_req = 2'b11; i_req_write = 2'b11;
    addr0 = 32'h10; addr1 = 32'h14; wd0 = 32'h1111_0000; wd1 = 32'h2222_0000;
    i_pready = 1'b1; i_pslverr = 1'b0; i_prdata = '0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (o_req_done == 2'b00 && n < 20);
      if (o_req_done == 2'b00) begin
        checks++; errors++;
        $display("FAIL fair_wait%0d actual=no_done required=done_within_20", k);
      end
      chk($sformatf("fair_grant%0d", k), o_req_done, exp_g[k]);
      chk($sformatf("fair_paddr%0d", k), o_paddr, (exp_g[k] == 2'b01) ? 32'h10 : 32'h14);
      chk($sformatf("fair_pwdata%0d", k), o_pwdata, (exp_g[k] == 2'b01) ? 32'h1111_0000 : 32'h2222_0000);
      if (k > 0) chk($sformatf("fair_spacing%0d", k), n, 4);
    end
    i_req = 2'b00;
    step();
    chk("fair_idle", o_busy, 0);

    // Long slave stall from requester 0 (read).
    i_req = 2'b01; i_req_write = 2'b00; addr0 = 32'h30; i_pready = 1'b0; i_prdata = 32'h7777_7777;
    step(); step();
    chk("stall_access", o_penable, 1);
`ifdef APB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) step();
    chk("to_hold_psel", o_psel, 1);
    step();
    chk("to_psel", o_psel, 0);
    chk("to_penable", o_penable, 0);
    chk("to_done", o_req_done, 2'b01);
    chk("to_err", o_req_err, 1);
    chk("to_rdata", o_req_rdata, 0);
    i_req = 2'b00; i_pready = 1'b1;
    step();
    chk("to_after_done", o_req_done, 0);
    chk("to_after_busy", o_busy, 0);
`else
    for (int c = 0; c < 20; c++) step();
    chk("stall_psel", o_psel, 1);
    chk("stall_penable", o_penable, 1);
    chk("stall_done", o_req_done, 0);
    i_pready = 1'b1; i_prdata = 32'hCAFE_F00D;
    step();
    chk("stall_done_pulse", o_req_done, 2'b01);
    chk("stall_rdata", o_req_rdata, 32'hCAFE_F00D);
    chk("stall_err", o_req_err, 0);
    i_req = 2'b00; i_pready = 1'b0;
    step();
    chk("stall_idle", o_busy, 0);
    chk("stall_rdata_clr", o_req_rdata, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
